stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (2..4) applied to tick_in.
REQ-002 SHALL have port clk_in  input  1  system clock, 1 MHz.
REQ-003 SHALL have port res  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tick_in  input  1  100 Hz square wave from the divider; asynchronous to clk_in logic.
REQ-005 SHALL have port start_stop  input  1  single-cycle command pulse.
REQ-006 SHALL have port lap  input  1  single-cycle command pulse.
REQ-007 SHALL have port clear  input  1  single-cycle command pulse.
REQ-008 SHALL have port disp_bcd  output  24  displayed time as six BCD nibbles {min_t, min_o, sec_t, sec_o, cs_t, cs_o}.
REQ-009 SHALL have port running  output  1  high in RUNNING or LAP.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse on rollover.

Function
REQ-011 SHALL pass tick_in through SYNC_STAGES flops, then produce tick_rise for exactly one cycle on each synchronized 0->1 transition; tick_rise asserts SYNC_STAGES+1 clk_in edges after the tick_in rising edge is first sampled.
REQ-012 SHALL implement FSM states IDLE, RUNNING, PAUSED, LAP.
REQ-013 SHALL transition: IDLE-start_stop->RUNNING; RUNNING-start_stop->PAUSED; RUNNING-lap->LAP; LAP-lap->RUNNING; LAP-start_stop->PAUSED; PAUSED-start_stop->RUNNING; PAUSED-clear->IDLE; IDLE-clear->IDLE.
REQ-014 SHALL ignore clear in RUNNING and LAP, and ignore lap in IDLE and PAUSED.
REQ-015 SHALL, when commands coincide, apply priority clear > start_stop > lap; lower-priority commands that cycle are dropped.
REQ-016 SHALL increment the live counter on tick_rise only when the state before the clock edge is RUNNING or LAP (a tick coinciding with a start_stop from RUNNING is counted; one coinciding with start_stop from PAUSED is not).
REQ-017 SHALL count BCD: cs_o 0-9, cs_t 0-9, sec_o 0-9, sec_t 0-5, min_o 0-9, min_t 0-5, each carry propagating in the same cycle.
REQ-018 SHALL wrap 59:59.99 -> 00:00.00 on the next counted tick, assert wrap for that one cycle, and keep the state unchanged.
REQ-019 SHALL, on clear accepted, zero the live counter and lap snapshot on the same edge.
REQ-020 SHALL, on entering LAP, capture the live counter value after that edge's increment into the lap snapshot; disp_bcd shows the snapshot while in LAP, otherwise the live counter.
REQ-021 SHALL register disp_bcd, running and wrap (no combinational input-to-output path); disp_bcd reflects a counted tick one cycle after tick_rise.

Reset
REQ-022 SHALL, while res is high, asynchronously force state IDLE, counter and snapshot 0, synchronizer flops 0, disp_bcd 24'h000000, running 0, wrap 0.
REQ-023 SHALL, on res asserted mid-count or mid-LAP, discard all progress; first tick_rise after release requires a fresh synchronized rising edge.

Configuration
REQ-024 SHALL support macro STOPWATCH_LAP_EN: defined -> LAP state, lap port and snapshot as specified; undefined -> no LAP state or snapshot register, lap port present but ignored, disp_bcd always shows the live counter.

Structure
REQ-025 SHALL place state encoding typedef, BCD digit limits (9, 5) and the 24-bit display width constant in shared package stopwatch_pkg.
REQ-026 SHALL implement synchronizer plus rising-edge detector as sub-module tick_sync (parameter SYNC_STAGES; ports clk_in, res, async_in, rise_pulse).

Verification
REQ-027 SHALL cover: reset, start_stop, 150 tick_in periods -> disp_bcd 24'h000150, running 1.
REQ-028 SHALL cover: preload to 59:59.98 via ticks, 2 more ticks -> disp_bcd 24'h000000, wrap high exactly one cycle, running stays 1.
REQ-029 SHALL cover: run to 00:01.00, lap, 50 ticks -> disp_bcd stays 24'h000100; lap again -> 24'h000150.
REQ-030 SHALL cover: clear and start_stop in same cycle while PAUSED at 00:00.42 -> state IDLE, disp_bcd 24'h000000, running 0; clear while RUNNING -> ignored.
REQ-031 SHALL cover: res pulse mid-count at 00:03.27 -> disp_bcd 24'h000000 immediately (asynchronous), state IDLE after release.
REQ-032 SHALL cover: build without STOPWATCH_LAP_EN, lap pulses during run -> no freeze, running unchanged, count continues.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch types, BCD limits and increment helper
// STOPWATCH_LAP_EN adds the LAP state to the encoding.
package stopwatch_pkg;

    localparam int DISP_W = 24;
    localparam logic [3:0] DIGIT_MAX_NINE = 4'd9;
    localparam logic [3:0] DIGIT_MAX_FIVE = 4'd5;
    localparam logic [DISP_W-1:0] BCD_MAX = 24'h595999;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED
`ifdef STOPWATCH_LAP_EN
        , ST_LAP
`endif
    } sw_state_t;

    // Ripple +1 through mm:ss.cc; digits 3 and 5 are the tens of seconds/minutes.
    function automatic logic [DISP_W-1:0] bcd_inc(input logic [DISP_W-1:0] v);
        logic [DISP_W-1:0] r;
        logic              carry;
        logic [3:0]        d;
        logic [3:0]        lim;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d   = v[i*4 +: 4];
            lim = (i == 3 || i == 5) ? DIGIT_MAX_FIVE : DIGIT_MAX_NINE;
            if (carry) begin
                if (d == lim) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_tick_sync.sv
// rtl/stopwatch_tick_sync.sv - tick_in synchronizer and rising-edge pulse
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic res,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   prev_q;
    logic                   armed_q;

    // armed_q waits for a real synchronized low, so a tick already high at reset release is not an edge.
    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            sync_q     <= '0;
            vld_q      <= '0;
            prev_q     <= 1'b0;
            armed_q    <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
            vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q     <= sync_q[SYNC_STAGES-1];
            armed_q    <= armed_q | (vld_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
            rise_pulse <= armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - stopwatch FSM, BCD counter and registered display
// STOPWATCH_LAP_EN enables the LAP state and snapshot register.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              res,
    input  logic              tick_in,
    input  logic              start_stop,
    input  logic              lap,
    input  logic              clear,
    output logic [DISP_W-1:0] disp_bcd,
    output logic              running,
    output logic              wrap
);

    sw_state_t         state_q, state_d;
    logic              tick_rise;
    logic              clear_acc;
    logic              count_en;
    logic [DISP_W-1:0] live_q, live_d;
    logic [DISP_W-1:0] view_d;
    logic              active_q, active_d;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .clk_in    (clk_in),
        .res       (res),
        .async_in  (tick_in),
        .rise_pulse(tick_rise)
    );

`ifdef STOPWATCH_LAP_EN
    logic [DISP_W-1:0] snap_q, snap_d;
    assign active_q = (state_q == ST_RUNNING) || (state_q == ST_LAP);
    assign active_d = (state_d == ST_RUNNING) || (state_d == ST_LAP);
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign active_q = (state_q == ST_RUNNING);
    assign active_d = (state_d == ST_RUNNING);
`endif

    // One command per cycle: the highest-priority pulse wins even if this state ignores it.
    always_comb begin
        state_d   = state_q;
        clear_acc = 1'b0;
        if (clear) begin
            if (state_q == ST_IDLE || state_q == ST_PAUSED) begin
                state_d   = ST_IDLE;
                clear_acc = 1'b1;
            end
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE:    state_d = ST_RUNNING;
                ST_RUNNING: state_d = ST_PAUSED;
                ST_PAUSED:  state_d = ST_RUNNING;
`ifdef STOPWATCH_LAP_EN
                ST_LAP:     state_d = ST_PAUSED;
`endif
                default:    state_d = ST_IDLE;
            endcase
`ifdef STOPWATCH_LAP_EN
        end else if (lap) begin
            if (state_q == ST_RUNNING) state_d = ST_LAP;
            else if (state_q == ST_LAP) state_d = ST_RUNNING;
`endif
        end
    end

    assign count_en = tick_rise && active_q;

    always_comb begin
        live_d = live_q;
        if (clear_acc) live_d = '0;
        else if (count_en) live_d = bcd_inc(live_q);
    end

`ifdef STOPWATCH_LAP_EN
    // Snapshot takes the post-increment value on the edge that enters LAP.
    always_comb begin
        snap_d = snap_q;
        if (clear_acc) snap_d = '0;
        else if (state_d == ST_LAP && state_q != ST_LAP) snap_d = live_d;
    end
    assign view_d = (state_d == ST_LAP) ? snap_d : live_d;

    always_ff @(posedge clk_in or posedge res) begin
        if (res) snap_q <= '0;
        else     snap_q <= snap_d;
    end
`else
    assign view_d = live_d;
`endif

    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            state_q  <= ST_IDLE;
            live_q   <= '0;
            disp_bcd <= '0;
            running  <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state_q  <= state_d;
            live_q   <= live_d;
            disp_bcd <= view_d;
            running  <= active_d;
            wrap     <= count_en && (live_q == BCD_MAX);
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - scoreboard bench for stopwatch_core
module tb_stopwatch_core;

    logic        clk_in = 1'b0;
    logic        res = 1'b1;
    logic        tick_in = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] disp_bcd;
    logic        running;
    logic        wrap;

    typedef struct {
        string       name;
        logic [23:0] disp;
        logic        run;
        logic        wrp;
        int          wcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   wrap_cnt = 0;

    stopwatch_core #(.SYNC_STAGES(2)) dut (
        .clk_in    (clk_in),
        .res       (res),
        .tick_in   (tick_in),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .disp_bcd  (disp_bcd),
        .running   (running),
        .wrap      (wrap)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (wrap === 1'b1) wrap_cnt++;

    // Monitor: drain every queued expectation against the outputs at this negedge.
    always @(negedge clk_in) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (disp_bcd !== e.disp || running !== e.run || wrap !== e.wrp ||
                (e.wcnt >= 0 && wrap_cnt != e.wcnt))
                $display("FAIL %s: got disp=%06h run=%b wrap=%b wraps=%0d, want disp=%06h run=%b wrap=%b wraps=%0d",
                         e.name, disp_bcd, running, wrap, wrap_cnt, e.disp, e.run, e.wrp, e.wcnt);
            else
                passed++;
        end
    end

    task automatic expect_out(input string name, input logic [23:0] d, input logic r,
                              input logic w, input int wc);
        exp_t e;
        e.name = name; e.disp = d; e.run = r; e.wrp = w; e.wcnt = wc;
        exp_q.push_back(e);
        @(negedge clk_in);
        #1;
    endtask

    task automatic cmd(input logic ss, input logic lp, input logic cl);
        start_stop = ss; lap = lp; clear = cl;
        @(posedge clk_in);
        #1;
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            repeat (4) @(posedge clk_in);
            #1;
            tick_in = 1'b0;
            repeat (4) @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        expect_out("reset", 24'h000000, 1'b0, 1'b0, 0);
        res = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;

        cmd(1'b1, 1'b0, 1'b0);
        expect_out("start", 24'h000000, 1'b1, 1'b0, 0);
        ticks(150);
        expect_out("150_ticks", 24'h000150, 1'b1, 1'b0, 0);
        cmd(1'b1, 1'b0, 1'b0);
        expect_out("pause", 24'h000150, 1'b0, 1'b0, 0);
        ticks(3);
        expect_out("paused_no_count", 24'h000150, 1'b0, 1'b0, 0);
        cmd(1'b0, 1'b0, 1'b1);
        expect_out("clear_paused", 24'h000000, 1'b0, 1'b0, 0);
        cmd(1'b1, 1'b0, 1'b0);
        ticks(100);
        expect_out("run_to_1s", 24'h000100, 1'b1, 1'b0, 0);

`ifdef STOPWATCH_LAP_EN
        cmd(1'b0, 1'b1, 1'b0);
        expect_out("lap_enter", 24'h000100, 1'b1, 1'b0, 0);
        ticks(50);
        expect_out("lap_frozen", 24'h000100, 1'b1, 1'b0, 0);
        cmd(1'b0, 1'b1, 1'b0);
        expect_out("lap_exit", 24'h000150, 1'b1, 1'b0, 0);
`else
        cmd(1'b0, 1'b1, 1'b0);
        expect_out("lap_ignored", 24'h000100, 1'b1, 1'b0, 0);
        ticks(25);
        cmd(1'b0, 1'b1, 1'b0);
        ticks(25);
        expect_out("lap_no_freeze", 24'h000150, 1'b1, 1'b0, 0);
`endif

        cmd(1'b0, 1'b0, 1'b1);
        expect_out("clear_running_ignored", 24'h000150, 1'b1, 1'b0, 0);
        cmd(1'b1, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 1'b1);
        expect_out("clear_to_idle", 24'h000000, 1'b0, 1'b0, 0);
        cmd(1'b1, 1'b0, 1'b0);
        ticks(42);
        expect_out("run_42", 24'h000042, 1'b1, 1'b0, 0);
        cmd(1'b1, 1'b0, 1'b0);
        expect_out("pause_42", 24'h000042, 1'b0, 1'b0, 0);
        cmd(1'b1, 1'b0, 1'b1);
        expect_out("clear_beats_start", 24'h000000, 1'b0, 1'b0, 0);
        cmd(1'b1, 1'b0, 1'b0);
        expect_out("restart", 24'h000000, 1'b1, 1'b0, 0);

        // Preload near the top of the range; the last steps to rollover are real ticks.
        @(negedge clk_in);
        force dut.live_q = 24'h595990;
        @(posedge clk_in);
        #1;
        release dut.live_q;
        expect_out("preload", 24'h595990, 1'b1, 1'b0, 0);
        ticks(8);
        expect_out("at_595998", 24'h595998, 1'b1, 1'b0, 0);
        ticks(1);
        expect_out("at_595999", 24'h595999, 1'b1, 1'b0, 0);
        ticks(1);
        expect_out("rollover", 24'h000000, 1'b1, 1'b0, 1);

        ticks(327);
        expect_out("run_327", 24'h000327, 1'b1, 1'b0, 1);
        @(posedge clk_in);
        #1;
        res = 1'b1;
        tick_in = 1'b1;
        expect_out("async_reset", 24'h000000, 1'b0, 1'b0, 1);
        repeat (2) @(posedge clk_in);
        #1;
        res = 1'b0;
        expect_out("idle_after_reset", 24'h000000, 1'b0, 1'b0, 1);
        cmd(1'b1, 1'b0, 1'b0);
        repeat (6) @(posedge clk_in);
        #1;
        expect_out("no_stale_tick", 24'h000000, 1'b1, 1'b0, 1);
        tick_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        ticks(1);
        expect_out("fresh_tick", 24'h000001, 1'b1, 1'b0, 1);

        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
